// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Decodes RV32I fields into SrcA/SrcB/Operation and presents them
//            to the ALU through a valid/ready handshake with a 2-entry skid.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               Opcode,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [DATA_WIDTH-1:0]    RD1,
    input  logic [DATA_WIDTH-1:0]    RD2,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic [DATA_WIDTH-1:0]    PC,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     Illegal
);

    localparam int ENTRY_W = 1 + OPCODE_LENGTH + 2 * DATA_WIDTH;

    localparam logic [6:0] c_OPC_R      = 7'b0110011;
    localparam logic [6:0] c_OPC_I      = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    localparam logic [OPCODE_LENGTH-1:0] c_ALU_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_XOR = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_SLL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_SRL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_SUB = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_SRA = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_BEQ = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_BNE = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_BGE = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_SLT = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_JAL = OPCODE_LENGTH'(4'b1101);
    localparam logic [OPCODE_LENGTH-1:0] c_ALU_BLT = OPCODE_LENGTH'(4'b1110);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_in_ready;
    logic [ENTRY_W-1:0]         r_out;
    logic [ENTRY_W-1:0]         r_skid;
    logic [ENTRY_W-1:0]         w_entry;
    logic                       w_ill;
    logic [OPCODE_LENGTH-1:0]   w_op;
    logic [DATA_WIDTH-1:0]      w_a;
    logic [DATA_WIDTH-1:0]      w_b;
    logic [DATA_WIDTH-1:0]      w_shamt;
    logic                       w_accept;
    logic                       w_drain;
    logic                       w_load_out_new;
    logic                       w_load_out_skid;
    logic                       w_load_skid;
    logic                       w_unused_funct7;

    // Only the alternate-encoding bit of funct7 steers the decode.
    assign w_unused_funct7 = ^{Funct7[6], Funct7[4:0]};
    assign w_shamt         = {{(DATA_WIDTH-5){1'b0}}, Imm[4:0]};

    always_comb begin
        w_ill = 1'b0;
        w_op  = c_ALU_ADD;
        w_a   = RD1;
        w_b   = Imm;
        case (Opcode)
            c_OPC_R: begin
                w_b = RD2;
                case (Funct3)
                    3'b000:  w_op = Funct7[5] ? c_ALU_SUB : c_ALU_ADD;
                    3'b001:  w_op = c_ALU_SLL;
                    3'b010:  w_op = c_ALU_SLT;
                    3'b100:  w_op = c_ALU_XOR;
                    3'b101:  w_op = Funct7[5] ? c_ALU_SRA : c_ALU_SRL;
                    3'b110:  w_op = c_ALU_OR;
                    3'b111:  w_op = c_ALU_AND;
                    default: w_ill = 1'b1;
                endcase
            end
            c_OPC_I: begin
                case (Funct3)
                    3'b000:  w_op = c_ALU_ADD;
                    3'b001: begin
                        w_op = c_ALU_SLL;
                        w_b  = w_shamt;
                    end
                    3'b010:  w_op = c_ALU_SLT;
                    3'b100:  w_op = c_ALU_XOR;
                    3'b101: begin
                        w_op = Funct7[5] ? c_ALU_SRA : c_ALU_SRL;
                        w_b  = w_shamt;
                    end
                    3'b110:  w_op = c_ALU_OR;
                    3'b111:  w_op = c_ALU_AND;
                    default: w_ill = 1'b1;
                endcase
            end
            c_OPC_LOAD, c_OPC_STORE: w_op = c_ALU_ADD;
            c_OPC_BRANCH: begin
                w_b = RD2;
                case (Funct3)
                    3'b000:  w_op = c_ALU_BEQ;
                    3'b001:  w_op = c_ALU_BNE;
                    3'b100:  w_op = c_ALU_BLT;
                    3'b101:  w_op = c_ALU_BGE;
                    default: w_ill = 1'b1;
                endcase
            end
            c_OPC_JAL, c_OPC_JALR: w_op = c_ALU_JAL;
            c_OPC_LUI:   w_a = '0;
            c_OPC_AUIPC: w_a = PC;
            default:     w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_op = '0;
            w_a  = '0;
            w_b  = '0;
        end
    end

    assign w_entry  = {w_ill, w_op, w_a, w_b};
    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid && out_ready;

    always_comb begin
        w_state_next    = r_state;
        w_load_out_new  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next   = ST_ONE;
                    w_load_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_out_new = 1'b1;
                end else if (w_accept) begin
                    w_state_next = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_drain) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_state_next    = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
            if (w_load_out_new) begin
                r_out <= w_entry;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_entry;
            end
        end
    end

    // The registered flag already tracks the skid; gating with reset keeps
    // upstream from handing over an instruction that reset would discard.
    assign in_ready  = r_in_ready && !reset;
    assign out_valid = (r_state != ST_EMPTY);
    assign {Illegal, Operation, SrcA, SrcB} = r_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Self-checking bench for alu_issue_stage against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    typedef struct packed {
        logic        ill;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    localparam logic [6:0] R_T = 7'b0110011;
    localparam logic [6:0] I_T = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  Opcode = '0;
    logic [2:0]  Funct3 = '0;
    logic [6:0]  Funct7 = '0;
    logic [31:0] RD1 = '0;
    logic [31:0] RD2 = '0;
    logic [31:0] Imm = '0;
    logic [31:0] PC = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        Illegal;

    int errors = 0;
    int checks = 0;
    int dut_outs = 0;
    bit model_live = 1'b0;
    bit zero_exp = 1'b0;
    ent_t q[$];

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
        .RD1(RD1), .RD2(RD2), .Imm(Imm), .PC(PC),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .Illegal(Illegal)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Table-driven reference decode; 4'hF marks an undecodable slot.
    function automatic ent_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] rd1,
                                        input logic [31:0] rd2, input logic [31:0] imm,
                                        input logic [31:0] pc);
        ent_t e;
        logic [3:0] alu_tab [8];
        logic [3:0] br_tab [8];
        alu_tab = '{4'h2, 4'h4, 4'hC, 4'hF, 4'h3, 4'h5, 4'h1, 4'h0};
        br_tab  = '{4'h8, 4'h9, 4'hF, 4'hF, 4'hE, 4'hB, 4'hF, 4'hF};
        e.ill = 1'b0;
        e.op  = 4'h2;
        e.a   = rd1;
        e.b   = imm;
        case (opc)
            R_T: begin
                e.b  = rd2;
                e.op = alu_tab[f3];
                if (f3 == 3'd0 && f7[5]) e.op = 4'h6;
                if (f3 == 3'd5 && f7[5]) e.op = 4'h7;
            end
            I_T: begin
                e.op = alu_tab[f3];
                if (f3 == 3'd5 && f7[5]) e.op = 4'h7;
                if (f3 == 3'd1 || f3 == 3'd5) e.b = {27'b0, imm[4:0]};
            end
            7'b0000011, 7'b0100011: e.op = 4'h2;
            BR: begin
                e.b  = rd2;
                e.op = br_tab[f3];
            end
            7'b1101111, 7'b1100111: e.op = 4'hD;
            LUI: e.a = '0;
            AUI: e.a = pc;
            default: e.op = 4'hF;
        endcase
        if (e.op == 4'hF) begin
            e.ill = 1'b1;
            e.op  = 4'h0;
            e.a   = '0;
            e.b   = '0;
        end
        return e;
    endfunction

    // Model: a FIFO of at most two decoded entries; head is what the ALU sees.
    always @(posedge clk) begin
        int n;
        bit acc;
        if (reset) begin
            q.delete();
            model_live = 1'b1;
            zero_exp   = 1'b1;
        end else if (model_live) begin
            n   = q.size();
            acc = in_valid && (n < 2);
            if (out_ready && n > 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_decode(Opcode, Funct3, Funct7, RD1, RD2, Imm, PC));
                zero_exp = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("in_ready", 64'(in_ready), 64'(!reset && q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("SrcA", 64'(SrcA), 64'(q[0].a));
                chk("SrcB", 64'(SrcB), 64'(q[0].b));
                chk("Operation", 64'(Operation), 64'(q[0].op));
                chk("Illegal", 64'(Illegal), 64'(q[0].ill));
            end else if (zero_exp) begin
                chk("zero_outputs", 64'({Illegal, Operation, SrcA, SrcB}), 64'(0));
            end
            if (out_valid && out_ready) dut_outs++;
        end
    end

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc);
        Opcode = opc; Funct3 = f3; Funct7 = f7;
        RD1 = rd1; RD2 = rd2; Imm = imm; PC = pc;
    endtask

    task automatic expect_out(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic ill);
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_SrcA"}, 64'(SrcA), 64'(a));
        chk({name, "_SrcB"}, 64'(SrcB), 64'(b));
        chk({name, "_Operation"}, 64'(Operation), 64'(op));
        chk({name, "_Illegal"}, 64'(Illegal), 64'(ill));
    endtask

    task automatic issue_check(input string name, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [31:0] ea,
                               input logic [31:0] eb, input logic [3:0] eop, input logic eill);
        drive(opc, f3, f7, rd1, rd2, imm, pc);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        expect_out(name, ea, eb, eop, eill);
        @(posedge clk); #1;
    endtask

    task automatic rand_instr(input bit legal_only);
        logic [6:0] opcs [9];
        logic [2:0] br_f3 [4];
        int k;
        opcs  = '{R_T, I_T, 7'b0000011, 7'b0100011, BR, 7'b1101111, 7'b1100111, LUI, AUI};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5};
        k = int'($urandom_range(0, 8));
        Opcode = opcs[k];
        Funct3 = 3'($urandom);
        Funct7 = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000;
        if (legal_only) begin
            if ((k == 0 || k == 1) && Funct3 == 3'd3) Funct3 = 3'd0;
            if (k == 4) Funct3 = br_f3[$urandom_range(0, 3)];
        end else if ($urandom_range(0, 7) == 0) begin
            Opcode = 7'($urandom);
            Funct7 = 7'($urandom);
        end
        RD1 = $urandom; RD2 = $urandom; Imm = $urandom; PC = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_fields", 64'({Illegal, Operation, SrcA, SrcB}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Directed decodes with hand-computed results
        issue_check("sub", R_T, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0, 32'd0, 32'd10, 32'd3, 4'b0110, 1'b0);
        issue_check("add", R_T, 3'b000, 7'b0000000, 32'd10, 32'd3, 32'd0, 32'd0, 32'd10, 32'd3, 4'b0010, 1'b0);
        issue_check("srai", I_T, 3'b101, 7'b0100000, 32'h80, 32'd9, 32'h405, 32'd0, 32'h80, 32'd5, 4'b0111, 1'b0);
        issue_check("lui", LUI, 3'b000, 7'b0, 32'hDEAD, 32'd9, 32'h12345000, 32'd0, 32'd0, 32'h12345000, 4'b0010, 1'b0);
        issue_check("auipc", AUI, 3'b000, 7'b0, 32'hDEAD, 32'd9, 32'd4, 32'h100, 32'h100, 32'd4, 4'b0010, 1'b0);
        issue_check("blt", BR, 3'b100, 7'b0, 32'd7, 32'd8, 32'd12, 32'd0, 32'd7, 32'd8, 4'b1110, 1'b0);
        issue_check("bge", BR, 3'b101, 7'b0, 32'd7, 32'd8, 32'd12, 32'd0, 32'd7, 32'd8, 4'b1011, 1'b0);
        issue_check("br_ill", BR, 3'b010, 7'b0, 32'd7, 32'd8, 32'd12, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b1);
        issue_check("r_ill", R_T, 3'b011, 7'b0, 32'd7, 32'd8, 32'd12, 32'd0, 32'd0, 32'd0, 4'b0000, 1'b1);

        // Backpressure: A held, B in skid, C waits upstream
        out_ready = 1'b0;
        drive(R_T, 3'b000, 7'b0, 32'd1, 32'd2, 32'd0, 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(I_T, 3'b100, 7'b0, 32'd5, 32'd0, 32'd7, 32'd0);
        @(posedge clk); #1;
        drive(R_T, 3'b111, 7'b0, 32'hF0, 32'h3C, 32'd0, 32'd0);
        @(negedge clk);
        expect_out("bp_A0", 32'd1, 32'd2, 4'b0010, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        expect_out("bp_A1", 32'd1, 32'd2, 4'b0010, 1'b0);
        chk("bp_in_ready_still_low", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        expect_out("bp_B", 32'd5, 32'd7, 4'b0011, 1'b0);
        chk("bp_in_ready_back", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        expect_out("bp_C", 32'hF0, 32'h3C, 4'b0000, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'(0));

        // Full-rate streaming of legal instructions
        @(posedge clk); #1;
        dut_outs = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_instr(1'b1);
            in_valid = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", 64'(in_ready), 64'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("stream_count", 64'(dut_outs), 64'(100));

        // Random handshakes, illegal encodings included
        for (int i = 0; i < 300; i++) begin
            rand_instr(1'b0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Reset while FULL
        out_ready = 1'b0;
        rand_instr(1'b1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        rand_instr(1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_fields", 64'({Illegal, Operation, SrcA, SrcB}), 64'(0));
        reset = 1'b0;
        issue_check("after_rst", R_T, 3'b001, 7'b0, 32'd3, 32'd4, 32'd0, 32'd0, 32'd3, 32'd4, 4'b0100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered issue stage that produces the operand pair and 4-bit `Operation` code consumed by the RV32I ALU. It decodes opcode/funct3/funct7 plus register, immediate and PC values into `SrcA`, `SrcB` and `Operation`. It presents them to the ALU through a valid/ready handshake with a 2-entry skid buffer, so stalls downstream never drop or duplicate an instruction. It sits between the register-read/immediate-generation logic and the ALU in the datapath.

## Interface
- `DATA_WIDTH`, 32, operand width.
- `OPCODE_LENGTH`, 4, width of `Operation`.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: upstream has an instruction.
- `in_ready` output 1: stage can accept an instruction.
- `Opcode` input 7: instruction[6:0].
- `Funct3` input 3: instruction[14:12].
- `Funct7` input 7: instruction[31:25].
- `RD1` input DATA_WIDTH: rs1 value.
- `RD2` input DATA_WIDTH: rs2 value.
- `Imm` input DATA_WIDTH: sign-extended immediate.
- `PC` input DATA_WIDTH: instruction address.
- `out_valid` output 1: `SrcA`/`SrcB`/`Operation` valid.
- `out_ready` input 1: ALU side accepts.
- `SrcA` output DATA_WIDTH: ALU operand A.
- `SrcB` output DATA_WIDTH: ALU operand B.
- `Operation` output OPCODE_LENGTH: ALU operation code.
- `Illegal` output 1: the issued instruction was not decodable; qualified by `out_valid`.

## Operation
- **Operation codes:** AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, BEQ 1000, BNE 1001, BGE 1011, SLT 1100, JAL/JALR 1101, BLT 1110.
- **R-type (0110011):** `SrcA`=RD1, `SrcB`=RD2.
  - f3 000: ADD if Funct7[5]=0, SUB if 1.
  - 111 AND; 110 OR; 100 XOR; 001 SLL; 010 SLT.
  - 101: SRA if Funct7[5]=1, else SRL.
  - 011 is illegal.
- **I-type ALU (0010011):** `SrcA`=RD1, `SrcB`=Imm.
  - Same funct3 mapping as R-type; 000 is always ADD.
  - For shifts, `SrcB`={27'b0, Imm[4:0]}; 101 selects SRA when Funct7[5]=1.
  - 011 is illegal.
- **Load (0000011) and Store (0100011):** ADD, `SrcA`=RD1, `SrcB`=Imm.
- **Branch (1100011):** `SrcA`=RD1, `SrcB`=RD2.
  - f3 000 BEQ, 001 BNE, 100 BLT, 101 BGE.
  - 010, 011, 110 and 111 are illegal.
- **JAL (1101111) and JALR (1100111):** 1101, `SrcA`=RD1, `SrcB`=Imm.
- **LUI (0110111):** ADD, `SrcA`=0, `SrcB`=Imm.
- **AUIPC (0010111):** ADD, `SrcA`=PC, `SrcB`=Imm.
- **Any other opcode, and every illegal case above:** `Illegal`=1, `Operation`=0000, `SrcA`=`SrcB`=0.
- **Storage:** one output register (OUT) and one skid register (SKID), each holding a valid bit plus decoded fields.
- **States:** EMPTY (OUT invalid), ONE (OUT valid, SKID invalid), FULL (both valid).
  - EMPTY: accept → ONE.
  - ONE: accept without drain → FULL; drain without accept → EMPTY; accept and drain together → ONE, OUT loads the new entry.
  - FULL: drain → ONE, OUT loads SKID. No accept is possible because `in_ready`=0.
- **Acceptance:** an instruction is accepted when `in_valid && in_ready`. Decode happens on the input side, so a stored entry never re-decodes.
- **Draining:** `out_valid && out_ready` drains OUT.

## Timing
- **Reset** (synchronous, held one or more cycles), on the next edge:
  - `out_valid`=0, `Illegal`=0, `SrcA`=`SrcB`=0, `Operation`=0000, SKID invalid.
  - `in_ready`=0 while `reset` is high; 1 in the first cycle after deassertion.
- **Latency:** an instruction accepted at edge N is on the outputs with `out_valid`=1 after edge N.
- **Throughput:** 1 instruction/cycle while `out_ready`=1.
- **`in_ready`** is registered and equals !SKID.valid. It falls the cycle after SKID fills and rises the cycle after SKID drains.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, all outputs hold constant.
- **Ordering:** instructions leave in arrival order; none is dropped or duplicated.
- **Reset mid-operation:** discards both entries with no partial output.
- **`out_ready` while `out_valid`=0:** no effect.

## Test plan
- **ADD/SUB:** `Opcode`=0110011, f3=000, f7=0100000, RD1=10, RD2=3 → one cycle later `Operation`=0110, `SrcA`=10, `SrcB`=3, `Illegal`=0. With f7=0000000 → `Operation`=0010.
- **SRAI/LUI/AUIPC:** SRAI with Imm=0x405 (f7[5]=1) → `Operation`=0111, `SrcB`=5. LUI with Imm=0x12345000 → `SrcA`=0, `SrcB`=0x12345000, `Operation`=0010. AUIPC with PC=0x100 → `SrcA`=0x100.
- **Branch:** f3=100 → 1110; f3=101 → 1011; f3=010 → `Illegal`=1, `Operation`=0000.
- **Backpressure:** stream A, B, C with `out_ready`=0.
  - A is held on the outputs; B goes into SKID; `in_ready`=0 from the following cycle; C is held upstream.
  - Raise `out_ready` → A, B, C appear in order on consecutive cycles.
- **Full-rate streaming:** `in_valid`=`out_ready`=1 for 100 random legal instructions → 100 outputs, one per cycle, each matching the reference decode; `in_ready` never drops.
- **Reset mid-operation:** assert reset in FULL state → next cycle `out_valid`=0 and all outputs 0; the first instruction after reset issues normally.
